// File: rtl/ysyx_22050550_div_pkg.sv
// Shared types for the iterative divider: FSM states, special-case encodings
// and the sign-fix decision helpers.
package ysyx_22050550_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  // Results that bypass the iteration and are written straight into DONE
  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_DIV0,
    SPC_OVF,
    SPC_ZERO
  } div_special_e;

  function automatic logic neg_quotient(input logic is_signed, input logic dend_sign,
                                        input logic dsor_sign);
    return is_signed & (dend_sign ^ dsor_sign);
  endfunction

  function automatic logic neg_remainder(input logic is_signed, input logic dend_sign);
    return is_signed & dend_sign;
  endfunction

endpackage

// File: rtl/ysyx_22050550_div_lzc.sv
// Leading-zero counter. count_o is meaningful only when zero_o is low.
module ysyx_22050550_div_lzc #(
  parameter int WIDTH = 64,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o,
  output logic             zero_o
);

  always_comb begin
    count_o = '0;
    zero_o  = (data_i == '0);
    // Scanning upward lets the highest set bit overwrite earlier hits
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ysyx_22050550_div_iter.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and W variants.
// Define YSYX_22050550_DIV_EARLY_OUT_EN to skip leading-zero iterations.
module ysyx_22050550_div_iter
  import ysyx_22050550_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Exu_InValid,
  output logic            io_Exu_InReady,
  input  logic            io_Exu_Signed,
  input  logic            io_Exu_Word,
  input  logic [XLEN-1:0] io_Exu_Dividend,
  input  logic [XLEN-1:0] io_Exu_Divisor,
  input  logic            io_Exu_Flush,
  output logic            io_Exu_OutValid,
  input  logic            io_Exu_OutReady,
  output logic [XLEN-1:0] io_Exu_Quotient,
  output logic [XLEN-1:0] io_Exu_Remainder
);

  localparam int WLEN = XLEN / 2;
  localparam int CNTW = $clog2(XLEN);

  // Handshake: a request moves on a clock edge where InValid & InReady & !Flush;
  // a result is consumed on an edge where OutValid & OutReady; neither side
  // may retract valid data, and Flush overrides everything.
  div_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsor_q, dsor_d;
  logic            sgn_q, sgn_d, word_q, word_d;
  logic            dend_neg_q, dend_neg_d, dsor_neg_q, dsor_neg_d;

  logic            accept, dend_s, dsor_s;
  logic [XLEN-1:0] dend_ext, dsor_ext, dend_abs, dsor_abs, dend_top, dend_rw;
  logic [CNTW-1:0] n_m1;
  div_special_e    spc;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  function automatic logic [XLEN-1:0] fix(input logic [XLEN-1:0] v, input logic neg,
                                          input logic word);
    logic [XLEN-1:0] t;
    t = neg ? -v : v;
    return word ? {{WLEN{t[WLEN-1]}}, t[WLEN-1:0]} : t;
  endfunction

`ifdef YSYX_22050550_DIV_EARLY_OUT_EN
  logic [CNTW-1:0] lz;
  logic            dend_zero;

  ysyx_22050550_div_lzc #(.WIDTH(XLEN)) u_lzc (
    .data_i  (dend_top),
    .count_o (lz),
    .zero_o  (dend_zero)
  );
`endif

  assign accept = io_Exu_InValid & (state_q == DIV_IDLE) & ~io_Exu_Flush;

  always_comb begin
    dend_s   = io_Exu_Word ? io_Exu_Dividend[WLEN-1] : io_Exu_Dividend[XLEN-1];
    dsor_s   = io_Exu_Word ? io_Exu_Divisor[WLEN-1]  : io_Exu_Divisor[XLEN-1];
    dend_ext = io_Exu_Word ? {{WLEN{io_Exu_Signed & dend_s}}, io_Exu_Dividend[WLEN-1:0]}
                           : io_Exu_Dividend;
    dsor_ext = io_Exu_Word ? {{WLEN{io_Exu_Signed & dsor_s}}, io_Exu_Divisor[WLEN-1:0]}
                           : io_Exu_Divisor;
    dend_abs = (io_Exu_Signed & dend_s) ? -dend_ext : dend_ext;
    dsor_abs = (io_Exu_Signed & dsor_s) ? -dsor_ext : dsor_ext;
    // Word dividends are top-aligned so the MSB-first shift works unchanged
    dend_top = io_Exu_Word ? {dend_abs[WLEN-1:0], {WLEN{1'b0}}} : dend_abs;
    dend_rw  = io_Exu_Word ? {{WLEN{io_Exu_Dividend[WLEN-1]}}, io_Exu_Dividend[WLEN-1:0]}
                           : io_Exu_Dividend;
    n_m1     = io_Exu_Word ? CNTW'(WLEN - 1) : CNTW'(XLEN - 1);
    spc      = SPC_NONE;
    if (dsor_ext == '0) spc = SPC_DIV0;
    // Word-mode overflow falls out of the normal iteration with the right value
    else if (io_Exu_Signed & ~io_Exu_Word & (&io_Exu_Divisor) &
             (io_Exu_Dividend == {1'b1, {(XLEN-1){1'b0}}})) spc = SPC_OVF;
`ifdef YSYX_22050550_DIV_EARLY_OUT_EN
    else if (dend_zero) spc = SPC_ZERO;
`endif
  end

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted[XLEN] | (shifted[XLEN-1:0] >= dsor_q);
    rem_nxt = ge ? (shifted[XLEN-1:0] - dsor_q) : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsor_d     = dsor_q;
    sgn_d      = sgn_q;
    word_d     = word_q;
    dend_neg_d = dend_neg_q;
    dsor_neg_d = dsor_neg_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          sgn_d      = io_Exu_Signed;
          word_d     = io_Exu_Word;
          dend_neg_d = dend_s;
          dsor_neg_d = dsor_s;
          dsor_d     = dsor_abs;
          rem_d      = '0;
          state_d    = DIV_DONE;
          unique case (spc)
            SPC_DIV0: begin
              quo_d = '1;
              rem_d = dend_rw;
            end
            SPC_OVF:  quo_d = {1'b1, {(XLEN-1){1'b0}}};
            SPC_ZERO: quo_d = '0;
            default: begin
              state_d = DIV_CALC;
`ifdef YSYX_22050550_DIV_EARLY_OUT_EN
              quo_d   = dend_top << lz;
              cnt_d   = n_m1 - lz;
`else
              quo_d   = dend_top;
              cnt_d   = n_m1;
`endif
            end
          endcase
        end
      end
      DIV_CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          quo_d   = fix(quo_nxt, neg_quotient(sgn_q, dend_neg_q, dsor_neg_q), word_q);
          rem_d   = fix(rem_nxt, neg_remainder(sgn_q, dend_neg_q), word_q);
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (io_Exu_OutReady) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (io_Exu_Flush) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsor_q     <= '0;
      sgn_q      <= 1'b0;
      word_q     <= 1'b0;
      dend_neg_q <= 1'b0;
      dsor_neg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsor_q     <= dsor_d;
      sgn_q      <= sgn_d;
      word_q     <= word_d;
      dend_neg_q <= dend_neg_d;
      dsor_neg_q <= dsor_neg_d;
    end
  end

  assign io_Exu_InReady   = (state_q == DIV_IDLE);
  assign io_Exu_OutValid  = (state_q == DIV_DONE);
  assign io_Exu_Quotient  = quo_q;
  assign io_Exu_Remainder = rem_q;

endmodule

// File: tb/tb_ysyx_22050550_div_iter.sv
// Directed and randomized checks of the iterative divider against an
// arithmetic reference model (RISC-V DIV/REM semantics).
module tb_ysyx_22050550_div_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_Exu_InValid, io_Exu_InReady, io_Exu_Signed, io_Exu_Word;
  logic [63:0] io_Exu_Dividend, io_Exu_Divisor;
  logic        io_Exu_Flush, io_Exu_OutValid, io_Exu_OutReady;
  logic [63:0] io_Exu_Quotient, io_Exu_Remainder;

  int vectors = 0;
  int miscompares = 0;

  ysyx_22050550_div_iter #(.XLEN(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_Exu_InValid   (io_Exu_InValid),
    .io_Exu_InReady   (io_Exu_InReady),
    .io_Exu_Signed    (io_Exu_Signed),
    .io_Exu_Word      (io_Exu_Word),
    .io_Exu_Dividend  (io_Exu_Dividend),
    .io_Exu_Divisor   (io_Exu_Divisor),
    .io_Exu_Flush     (io_Exu_Flush),
    .io_Exu_OutValid  (io_Exu_OutValid),
    .io_Exu_OutReady  (io_Exu_OutReady),
    .io_Exu_Quotient  (io_Exu_Quotient),
    .io_Exu_Remainder (io_Exu_Remainder)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic with the RISC-V corner-case rules
  function automatic void model(input logic sg, input logic wd, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output int lat);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        q32, r32;
    logic [63:0]        mag;
    int                 n, lz;
    n = wd ? 32 : 64;
    lat = n + 1;
    if (wd) begin
      if (b[31:0] == 32'd0) begin
        q = '1; r = {{32{a[31]}}, a[31:0]}; lat = 1; return;
      end
      if (sg) begin
        sa32 = a[31:0]; sb32 = b[31:0];
        if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
          q32 = a[31:0]; r32 = 32'd0;
        end else begin
          q32 = sa32 / sb32; r32 = sa32 % sb32;
        end
        mag = {32'd0, a[31] ? (32'd0 - a[31:0]) : a[31:0]};
      end else begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
        mag = {32'd0, a[31:0]};
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; lat = 1; return;
      end
      if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; lat = 1; return;
      end
      if (sg) begin
        sa = a; sb = b; q = sa / sb; r = sa % sb;
        mag = a[63] ? (64'd0 - a) : a;
      end else begin
        q = a / b; r = a % b;
        mag = a;
      end
    end
`ifdef YSYX_22050550_DIV_EARLY_OUT_EN
    lz = 0;
    for (int i = n - 1; i >= 0 && !mag[i]; i--) lz++;
    lat = (lz == n) ? 1 : n - lz + 1;
`else
    lz = 0;
    if (mag == 64'd0) lat = n + 1 + lz;
`endif
  endfunction

  task automatic run_op(input string tag, input logic sg, input logic wd,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] eq, er;
    int elat, lat, w;
    model(sg, wd, a, b, eq, er, elat);
    @(negedge clock);
    w = 0;
    while (!io_Exu_InReady && w < 200) begin @(negedge clock); w++; end
    chk({tag, "_inready"}, 64'(io_Exu_InReady), 64'd1);
    io_Exu_Signed = sg; io_Exu_Word = wd; io_Exu_Dividend = a; io_Exu_Divisor = b;
    io_Exu_InValid = 1'b1; io_Exu_OutReady = (hold == 0);
    @(posedge clock); #1;
    io_Exu_InValid  = 1'b0;
    io_Exu_Dividend = {$urandom(), $urandom()};
    io_Exu_Divisor  = {$urandom(), $urandom()};
    io_Exu_Signed   = 1'($urandom_range(0, 1));
    io_Exu_Word     = 1'($urandom_range(0, 1));
    lat = 1;
    while (!io_Exu_OutValid && lat < 200) begin @(posedge clock); #1; lat++; end
    chk({tag, "_valid"}, 64'(io_Exu_OutValid), 64'd1);
    chk({tag, "_q"}, io_Exu_Quotient, eq);
    chk({tag, "_r"}, io_Exu_Remainder, er);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({tag, "_hold_v"}, 64'(io_Exu_OutValid), 64'd1);
      chk({tag, "_hold_q"}, io_Exu_Quotient, eq);
      chk({tag, "_hold_r"}, io_Exu_Remainder, er);
    end
    io_Exu_OutReady = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_drain"}, 64'(io_Exu_OutValid), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0, 1: return {$urandom(), $urandom()};
      2:    return 64'($urandom_range(0, 20));
      3:    return '1;
      4:    return 64'h8000_0000_0000_0000;
      5:    return {32'd0, $urandom()};
      default: return {32'hFFFF_FFFF, 1'b1, 31'($urandom())};
    endcase
  endfunction

  initial begin
    int cnt;
    reset = 1'b0;
    io_Exu_InValid = 1'b0; io_Exu_Signed = 1'b0; io_Exu_Word = 1'b0;
    io_Exu_Dividend = '0; io_Exu_Divisor = '0; io_Exu_Flush = 1'b0; io_Exu_OutReady = 1'b1;
    #1;
    chk("rst_inready", 64'(io_Exu_InReady), 64'd1);
    chk("rst_outvalid", 64'(io_Exu_OutValid), 64'd0);
    chk("rst_q", io_Exu_Quotient, 64'd0);
    chk("rst_r", io_Exu_Remainder, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_op("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 0);
    run_op("s_m7_2", 1'b1, 1'b0, -64'sd7, 64'd2, 0);
    run_op("s_7_m2", 1'b1, 1'b0, 64'd7, -64'sd2, 0);
    run_op("div0", 1'b0, 1'b0, 64'd5, 64'd0, 0);
    run_op("ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op("w_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("wu_ff_1", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
    run_op("hold10", 1'b1, 1'b0, 64'd123456789, -64'sd1000, 10);

    // Flush on the 20th CALC cycle, then a fresh request
    @(negedge clock);
    io_Exu_Signed = 1'b0; io_Exu_Word = 1'b0; io_Exu_Dividend = 64'd1000; io_Exu_Divisor = 64'd3;
    io_Exu_InValid = 1'b1; io_Exu_OutReady = 1'b1;
    @(posedge clock); #1;
    io_Exu_InValid = 1'b0;
    repeat (19) @(posedge clock);
    #1 io_Exu_Flush = 1'b1;
    @(posedge clock); #1;
    io_Exu_Flush = 1'b0;
    chk("flush_calc_v", 64'(io_Exu_OutValid), 64'd0);
    chk("flush_calc_rdy", 64'(io_Exu_InReady), 64'd1);
    cnt = 0;
    repeat (70) begin @(posedge clock); #1; if (io_Exu_OutValid) cnt++; end
    chk("flush_calc_quiet", 64'(cnt), 64'd0);
    run_op("after_flush", 1'b0, 1'b0, 64'd9, 64'd3, 0);

    // Flush with InValid in IDLE must not accept (div-by-zero would finish at once)
    @(negedge clock);
    io_Exu_Dividend = 64'd5; io_Exu_Divisor = 64'd0; io_Exu_InValid = 1'b1; io_Exu_Flush = 1'b1;
    @(posedge clock); #1;
    io_Exu_InValid = 1'b0; io_Exu_Flush = 1'b0;
    chk("flush_idle_v", 64'(io_Exu_OutValid), 64'd0);
    chk("flush_idle_rdy", 64'(io_Exu_InReady), 64'd1);

    // Flush in DONE together with OutReady
    @(negedge clock);
    io_Exu_Signed = 1'b0; io_Exu_Word = 1'b0; io_Exu_Dividend = 64'd5; io_Exu_Divisor = 64'd0;
    io_Exu_InValid = 1'b1; io_Exu_OutReady = 1'b0;
    @(posedge clock); #1;
    io_Exu_InValid = 1'b0;
    chk("flush_done_pre", 64'(io_Exu_OutValid), 64'd1);
    io_Exu_Flush = 1'b1; io_Exu_OutReady = 1'b1;
    @(posedge clock); #1;
    io_Exu_Flush = 1'b0;
    chk("flush_done_v", 64'(io_Exu_OutValid), 64'd0);
    chk("flush_done_rdy", 64'(io_Exu_InReady), 64'd1);

    // Asynchronous reset in the middle of a calculation
    @(negedge clock);
    io_Exu_Dividend = 64'hDEAD_BEEF_1234_5678; io_Exu_Divisor = 64'd7; io_Exu_InValid = 1'b1;
    @(posedge clock); #1;
    io_Exu_InValid = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_inready", 64'(io_Exu_InReady), 64'd1);
    chk("arst_outvalid", 64'(io_Exu_OutValid), 64'd0);
    chk("arst_q", io_Exu_Quotient, 64'd0);
    chk("arst_r", io_Exu_Remainder, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_div_iter.md
Name: ysyx_22050550_div_iter

Overview:
Parametrised radix-2 restoring integer divider for the EXU. It serves RV64M-style DIV/DIVU/REM/REMU and their W variants. Operands are latched at accept, so EXU may change inputs after the handshake. RISC-V divide-by-zero and signed-overflow results are produced by a 1-cycle bypass. The result has a valid/ready output handshake with backpressure, and a flush aborts any operation.

Parameters:
XLEN, 64, datapath width; even, >= 8
WLEN, XLEN/2, word-mode operand width (derived, not overridable)
CNTW, $clog2(XLEN), iteration counter width

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
io_Exu_InValid  in  1  request valid
io_Exu_InReady  out  1  divider can accept
io_Exu_Signed  in  1  1 = signed divide/remainder
io_Exu_Word  in  1  1 = W op on low WLEN bits
io_Exu_Dividend  in  XLEN  dividend
io_Exu_Divisor  in  XLEN  divisor
io_Exu_Flush  in  1  abort current op
io_Exu_OutValid  out  1  result valid
io_Exu_OutReady  in  1  consumer takes result
io_Exu_Quotient  out  XLEN  quotient
io_Exu_Remainder  out  XLEN  remainder

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, remainder/quotient regs=0. Outputs: InReady=1, OutValid=0, Quotient=0, Remainder=0.
- States: IDLE, CALC, DONE. InReady = (state==IDLE). OutValid = (state==DONE).
- Accept = InValid & InReady & !Flush.
  - At accept, latch signed, word, both operands (W: low WLEN bits), dividend sign, and divisor sign.
  - Latch |dividend| and |divisor| when signed, else raw values.
- Special cases, decided at accept, go IDLE->DONE with no CALC:
  - divisor==0 (over effective width): Q = all ones, R = dividend.
  - signed & dividend==MIN & divisor==-1: Q = MIN, R = 0.
- Normal flow: IDLE->CALC, counter = N-1, where N = XLEN (or WLEN if word).
  - Each CALC cycle produces one quotient bit MSB-first.
  - Trial subtract of divisor from the shifted partial remainder; if it is non-negative, keep the difference and set the q-bit.
  - At counter==0, CALC->DONE.
  - OutValid asserts exactly N+1 cycles after the accept edge; 65 for XLEN=64 full, 33 for word.
- Sign fix on the DONE value:
  - Q is negated iff signed & (dend_sign ^ dsor_sign).
  - R is negated iff signed & dend_sign.
  - Special-case results are not sign-fixed.
- Word mode: the WLEN-bit Q/R are sign-extended from bit WLEN-1 to XLEN for both signed and unsigned ops (RV64 W semantics).
- DONE holds Q/R stable until OutValid&OutReady; then ->IDLE. The next accept is possible the cycle after.
- Flush (any state): next state IDLE, counter cleared, OutValid deasserts next cycle.
  - Flush in IDLE with InValid: no accept.
  - Flush in DONE with OutReady same cycle: result counts as consumed, state ->IDLE.
- Input changes after accept have no effect on the result.
- Quotient/Remainder outputs are don't-care except in DONE; the implementation drives the registered values.

Optional Feature:
Macro YSYX_22050550_DIV_EARLY_OUT_EN.
- Defined: at accept, a leading-zero count L of |dividend| (effective width) pre-shifts the dividend by L, and the counter starts at N-1-L.
  - Dividend==0 (nonzero divisor): IDLE->DONE directly, Q=0, R=0.
  - Latency = N-L+1 cycles.
- Undefined: fixed latency N+1 for all non-special ops; there is no LZC logic.
- Results are identical either way.

Decomposition:
- Package ysyx_22050550_div_pkg: state enum (IDLE/CALC/DONE), sign-fix/negate function, special-case encodings.
- Sub-module ysyx_22050550_div_lzc (parametrised leading-zero counter, width XLEN). It is instantiated only under YSYX_22050550_DIV_EARLY_OUT_EN.

Test Plan:
- Unsigned 64-bit: 100 / 7, OutReady=1 -> Q=14, R=2; OutValid exactly 65 cycles after accept (fixed-latency build).
- Signed: -7 / 2 -> Q=0xFFFF_FFFF_FFFF_FFFD (-3), R=0xFFFF_FFFF_FFFF_FFFF (-1); 7 / -2 -> Q=-3, R=1.
- Special cases: 5 / 0 -> Q=all ones, R=5, OutValid 1 cycle after accept; signed 0x8000_0000_0000_0000 / -1 -> Q=0x8000_0000_0000_0000, R=0.
- Word mode: signed 0x0000_0000_8000_0000 / 0xFFFF_FFFF -> Q=0xFFFF_FFFF_8000_0000, R=0, latency 33; unsigned 0xFFFF_FFFF / 1 -> Q=0xFFFF_FFFF_FFFF_FFFF.
- Backpressure, input change, flush:
  - Hold OutReady=0 for 10 cycles in DONE -> Q/R and OutValid stable.
  - Change inputs after accept -> result unchanged.
  - Flush at CALC cycle 20 -> IDLE next cycle, no OutValid; a new 9/3 is accepted next and yields Q=3, R=0.
- Reset mid-CALC -> InReady=1, OutValid=0, Q=R=0 immediately, without waiting for a clock edge.
